// File: rtl/digit_serial_addsub_if.sv
// Handshake and operand/result bundle for digit_serial_addsub.
//   master: controller side (drives start/sub/a/b/c_in, receives status/result)
//   slave : adder side (receives request, drives busy/done/result/flags)
interface digit_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds or subtracts a WIDTH-bit operand pair
// DIGIT bits per clock, LSB digit first, with the inter-digit carry held in a
// register. WIDTH must be an integer multiple of DIGIT; N = WIDTH/DIGIT
// compute cycles per operation.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of digit_serial_addsub_if:
//           start/sub/a/b/c_in sampled in IDLE; busy high in RUN;
//           done one-cycle pulse; result/c_out/overflow/zero held until the
//           next operation completes.
module digit_serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  digit_serial_addsub_if.slave bus
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_out_q, c_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;

  logic [DIGIT:0]       digit_sum;
  logic                 msb_cin;
  logic [WIDTH+DIGIT-1:0] shift_cat;

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    digit_sum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit's top bit, recovered from the sum bit; avoids a
    // separate (DIGIT-1)-bit adder and works for DIGIT=1.
    msb_cin   = digit_sum[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
    // New digit enters from the top; concatenation form stays legal for N=1.
    shift_cat = {digit_sum[DIGIT-1:0], acc_q};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = shift_cat[WIDTH+DIGIT-1:DIGIT];
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          // Commit on the last RUN edge so result/flags are valid while done=1.
          result_d   = acc_d;
          c_out_d    = digit_sum[DIGIT];
          overflow_d = msb_cin ^ digit_sum[DIGIT];
          zero_d     = (acc_d == '0);
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: WIDTH=8, DIGIT=4 (N=2)
  digit_serial_addsub_if #(.WIDTH(8)) if8 ();
  digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  // Sweep instances: WIDTH=32, DIGIT = 1, 4, 8, 32 driven in lockstep
  logic        sw_start = 1'b0;
  logic        sw_sub   = 1'b0;
  logic        sw_cin   = 1'b0;
  logic [31:0] sw_a     = '0;
  logic [31:0] sw_b     = '0;

  digit_serial_addsub_if #(.WIDTH(32)) if_d1  ();
  digit_serial_addsub_if #(.WIDTH(32)) if_d4  ();
  digit_serial_addsub_if #(.WIDTH(32)) if_d8  ();
  digit_serial_addsub_if #(.WIDTH(32)) if_d32 ();

  digit_serial_addsub #(.WIDTH(32), .DIGIT(1))  dut_d1  (.clk(clk), .rst_n(rst_n), .bus(if_d1));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(4))  dut_d4  (.clk(clk), .rst_n(rst_n), .bus(if_d4));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(8))  dut_d8  (.clk(clk), .rst_n(rst_n), .bus(if_d8));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(32)) dut_d32 (.clk(clk), .rst_n(rst_n), .bus(if_d32));

  assign if_d1.start  = sw_start; assign if_d1.sub  = sw_sub; assign if_d1.a  = sw_a; assign if_d1.b  = sw_b; assign if_d1.c_in  = sw_cin;
  assign if_d4.start  = sw_start; assign if_d4.sub  = sw_sub; assign if_d4.a  = sw_a; assign if_d4.b  = sw_b; assign if_d4.c_in  = sw_cin;
  assign if_d8.start  = sw_start; assign if_d8.sub  = sw_sub; assign if_d8.a  = sw_a; assign if_d8.b  = sw_b; assign if_d8.c_in  = sw_cin;
  assign if_d32.start = sw_start; assign if_d32.sub = sw_sub; assign if_d32.a = sw_a; assign if_d32.b = sw_b; assign if_d32.c_in = sw_cin;

  logic        sw_done [4];
  logic [31:0] sw_res  [4];
  logic        sw_co   [4];
  logic        sw_ov   [4];
  logic        sw_busy [4];
  logic        sw_zero [4];

  assign sw_done[0] = if_d1.done;  assign sw_res[0] = if_d1.result;  assign sw_co[0] = if_d1.c_out;  assign sw_ov[0] = if_d1.overflow;
  assign sw_done[1] = if_d4.done;  assign sw_res[1] = if_d4.result;  assign sw_co[1] = if_d4.c_out;  assign sw_ov[1] = if_d4.overflow;
  assign sw_done[2] = if_d8.done;  assign sw_res[2] = if_d8.result;  assign sw_co[2] = if_d8.c_out;  assign sw_ov[2] = if_d8.overflow;
  assign sw_done[3] = if_d32.done; assign sw_res[3] = if_d32.result; assign sw_co[3] = if_d32.c_out; assign sw_ov[3] = if_d32.overflow;
  assign sw_busy[0] = if_d1.busy;  assign sw_zero[0] = if_d1.zero;
  assign sw_busy[1] = if_d4.busy;  assign sw_zero[1] = if_d4.zero;
  assign sw_busy[2] = if_d8.busy;  assign sw_zero[2] = if_d8.zero;
  assign sw_busy[3] = if_d32.busy; assign sw_zero[3] = if_d32.zero;

  // Drive one 8-bit operation, scramble the operand inputs after the start
  // cycle, and report latency (posedges counted from the start-sample edge),
  // the outputs in the done cycle, and done one cycle later.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci,
                        output int lat, output logic [7:0] r, output logic co, output logic ov,
                        output logic z, output logic done_after);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.sub = s; if8.c_in = ci; if8.start = 1'b1;
    lat = -1; r = '0; co = 1'b0; ov = 1'b0; z = 1'b0; done_after = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        if8.start = 1'b0; if8.a = ~a; if8.b = 8'h5A; if8.sub = ~s; if8.c_in = ~ci;
      end
      if (if8.done) begin
        lat = i; r = if8.result; co = if8.c_out; ov = if8.overflow; z = if8.zero;
        @(posedge clk); #1;
        done_after = if8.done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.result, if8.c_out, if8.overflow, if8.zero} !== 13'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b result=%h c_out=%b ov=%b zero=%b, expected all 0",
               if8.busy, if8.done, if8.result, if8.c_out, if8.overflow, if8.zero);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sw_busy[k], sw_done[k], sw_res[k], sw_co[k], sw_ov[k], sw_zero[k]} !== 37'b0) begin
        errors++;
        $display("FAIL reset32_%0d: busy=%b done=%b result=%h c_out=%b ov=%b zero=%b, expected all 0",
                 k, sw_busy[k], sw_done[k], sw_res[k], sw_co[k], sw_ov[k], sw_zero[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic ci, input logic [7:0] er,
                           input logic eco, input logic eov, input logic ez);
    int lat; logic [7:0] r; logic co, ov, z, da;
    do_op8(a, b, s, ci, lat, r, co, ov, z, da);
    checks++;
    if ({r, co, ov, z} !== {er, eco, eov, ez}) begin
      errors++;
      $display("FAIL %s_value: got result=%h c_out=%b ov=%b zero=%b, expected result=%h c_out=%b ov=%b zero=%b",
               name, r, co, ov, z, er, eco, eov, ez);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d, expected 3", name, lat);
    end
    checks++;
    if (da !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done still %b one cycle later, expected 0", name, da);
    end
  endtask

  task automatic test_add();
    check_op8("add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_carry_chain();
    check_op8("carry", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_subtract();
    check_op8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    check_op8("sub_ovf",    8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    int extra; int seen;
    @(negedge clk);
    if8.a = 8'h10; if8.b = 8'h20; if8.sub = 1'b0; if8.c_in = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got %b, expected 1", if8.busy);
    end
    @(negedge clk);
    if8.a = 8'h55; if8.b = 8'h11; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (if8.done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1 || if8.result !== 8'h30) begin
      errors++;
      $display("FAIL ignore_result: done_seen=%0d result=%h, expected done_seen=1 result=30", seen, if8.result);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if8.done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_extra_done: got %0d pulses, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int ndone; int first; int second; int bad;
    ndone = 0; first = -1; second = -1; bad = 0;
    @(negedge clk);
    if8.a = 8'h03; if8.b = 8'h04; if8.sub = 1'b0; if8.c_in = 1'b0; if8.start = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        ndone++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (if8.result !== ((ndone == 0) ? 8'h30 : 8'h07)) bad++;
    end
    @(negedge clk);
    if8.start = 1'b0;
    checks++;
    if (ndone !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, expected 3", ndone);
    end
    checks++;
    if (first !== 3) begin
      errors++;
      $display("FAIL b2b_first: got first done at cycle %0d, expected 3", first);
    end
    checks++;
    if (second - first !== 4) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles, expected 4", second - first);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_stable: got %0d cycles with wrong held result, expected 0", bad);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int pulses; int lat; logic [7:0] r; logic co, ov, z, da;
    @(negedge clk);
    if8.a = 8'hAA; if8.b = 8'h11; if8.sub = 1'b0; if8.c_in = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_run_busy: got %b, expected 1", if8.busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.result, if8.c_out, if8.overflow, if8.zero} !== 13'b0) begin
      errors++;
      $display("FAIL rst_run_outputs: busy=%b done=%b result=%h c_out=%b ov=%b zero=%b, expected all 0",
               if8.busy, if8.done, if8.result, if8.c_out, if8.overflow, if8.zero);
    end
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (if8.done) pulses++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (if8.done || if8.busy) pulses++; end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_run_no_done: got %0d cycles with done/busy, expected 0", pulses);
    end
    do_op8(8'h12, 8'h34, 1'b0, 1'b0, lat, r, co, ov, z, da);
    checks++;
    if ({r, co, ov, z} !== {8'h46, 1'b0, 1'b0, 1'b0} || lat !== 3) begin
      errors++;
      $display("FAIL rst_run_after: got result=%h c_out=%b ov=%b zero=%b lat=%0d, expected result=46 c_out=0 ov=0 zero=0 lat=3",
               r, co, ov, z, lat);
    end
  endtask

  task automatic test_param_sweep();
    int          lat_exp [4];
    int          seen    [4];
    logic [31:0] bb;
    logic [31:0] er;
    logic        eco, eov, c;
    lat_exp[0] = 33; lat_exp[1] = 9; lat_exp[2] = 5; lat_exp[3] = 2;
    for (int op = 0; op < 1000; op++) begin
      @(negedge clk);
      case (op)
        0: begin sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_sub = 1'b0; sw_cin = 1'b0; end
        1: begin sw_a = 32'h8000_0000; sw_b = 32'h0000_0001; sw_sub = 1'b1; sw_cin = 1'b0; end
        2: begin sw_a = 32'h7FFF_FFFF; sw_b = 32'h0000_0000; sw_sub = 1'b0; sw_cin = 1'b1; end
        3: begin sw_a = 32'h1234_5678; sw_b = 32'h1234_5678; sw_sub = 1'b1; sw_cin = 1'b0; end
        default: begin
          sw_a = $urandom; sw_b = $urandom;
          sw_sub = 1'($urandom_range(0, 1)); sw_cin = 1'($urandom_range(0, 1));
        end
      endcase
      bb  = sw_sub ? ~sw_b : sw_b;
      c   = sw_sub ? 1'b1 : sw_cin;
      {eco, er} = {1'b0, sw_a} + {1'b0, bb} + {32'b0, c};
      eov = (sw_a[31] == bb[31]) && (er[31] != sw_a[31]);
      sw_start = 1'b1;
      for (int k = 0; k < 4; k++) seen[k] = 0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin sw_start = 1'b0; sw_a = ~sw_a; sw_b = $urandom; end
        for (int k = 0; k < 4; k++) begin
          if (sw_done[k] && seen[k] == 0) begin
            seen[k] = 1;
            checks++;
            if ({sw_res[k], sw_co[k], sw_ov[k]} !== {er, eco, eov}) begin
              errors++;
              $display("FAIL sweep%0d_op%0d_value: got result=%h c_out=%b ov=%b, expected result=%h c_out=%b ov=%b",
                       k, op, sw_res[k], sw_co[k], sw_ov[k], er, eco, eov);
            end
            checks++;
            if (i !== lat_exp[k]) begin
              errors++;
              $display("FAIL sweep%0d_op%0d_latency: got %0d, expected %0d", k, op, i, lat_exp[k]);
            end
          end
        end
        if (seen[0] + seen[1] + seen[2] + seen[3] == 4) break;
      end
      for (int k = 0; k < 4; k++) begin
        if (seen[k] == 0) begin
          checks++;
          errors++;
          $display("FAIL sweep%0d_op%0d_timeout: got no done in 40 cycles, expected done at %0d", k, op, lat_exp[k]);
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_subtract();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
